// File: rtl/btn_seq_pkg.sv
// btn_seq_pkg
// Shared definitions for the button-sequence detector:
//   - fail_table : elaboration-time KMP failure function of the pattern
//   - LED_*      : bit positions on the 16-bit board LED bus
//   - params_ok  : legal parameter range check used by the top
package btn_seq_pkg;

   localparam int MAX_SEQ   = 16;
   localparam int MAX_SYM_W = 3;
   localparam int FAIL_W    = 5;

   localparam int LED_SEEN    = 0;
   localparam int LED_PROG_LO = 4;
   localparam int LED_PROG_W  = 4;
   localparam int LED_CNT_LO  = 8;
   localparam int LED_CNT_W   = 8;

   function automatic int sym_at(input logic [MAX_SEQ*MAX_SYM_W-1:0] pat,
                                 input int idx, input int sym_w);
      logic [MAX_SEQ*MAX_SYM_W-1:0] t;
      t = pat >> (idx * sym_w);
      return int'(t[MAX_SYM_W-1:0]) & ((1 << sym_w) - 1);
   endfunction

   // Entry k (FAIL_W bits at k*FAIL_W) is the length of the longest proper
   // prefix of pattern[0..k-1] that is also a suffix of it.
   function automatic logic [(MAX_SEQ+1)*FAIL_W-1:0] fail_table(
      input logic [MAX_SEQ*MAX_SYM_W-1:0] pat,
      input int seq_len, input int sym_w);
      int f [MAX_SEQ+1];
      int k;
      logic [(MAX_SEQ+1)*FAIL_W-1:0] r;
      for (int i = 0; i <= MAX_SEQ; i++) f[i] = 0;
      k = 0;
      for (int i = 1; i < MAX_SEQ; i++) begin
         if (i < seq_len) begin
            while (k > 0 && sym_at(pat, i, sym_w) != sym_at(pat, k, sym_w))
               k = f[k];
            if (sym_at(pat, i, sym_w) == sym_at(pat, k, sym_w))
               k = k + 1;
            f[i+1] = k;
         end
      end
      r = '0;
      for (int i = 0; i <= MAX_SEQ; i++)
         r[i*FAIL_W +: FAIL_W] = FAIL_W'(f[i]);
      return r;
   endfunction

   function automatic bit params_ok(input int n_btn, input int seq_len,
                                    input int debounce_cycles, input int cnt_w);
      return (n_btn >= 2) && (n_btn <= 8) && (seq_len >= 2) && (seq_len <= MAX_SEQ)
             && (debounce_cycles >= 1) && (cnt_w >= 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One push-button: 2-flop synchroniser, stability counter and a registered
// one-cycle pulse on each rising edge of the debounced level.
//   cp      : clock
//   rst     : synchronous active-high reset
//   btn_raw : asynchronous button level, 1 = pressed
//   level   : debounced level
//   press   : 1-cycle pulse, the cycle after level rises
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic cp,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1, sync2;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge cp) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         level_d <= level;
         press   <= level & ~level_d;
         // Any cycle where the synchronised input agrees with the accepted
         // level restarts the stability window.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_seq_detector.sv
// btn_seq_detector
// Debounces N_BTN buttons, turns each press into a symbol and matches the
// symbol stream against PATTERN with a KMP progress machine.
//   cp          : clock
//   rst         : synchronous active-high reset
//   btn         : raw button levels, 1 = pressed
//   progress    : pattern symbols currently matched
//   match       : 1-cycle pulse on a completed pattern
//   match_count : saturating number of completed matches
//   led_pin     : [0] match seen, [7:4] progress, [15:8] match_count[7:0]
module btn_seq_detector
   import btn_seq_pkg::*;
#(
   parameter int N_BTN           = 2,
   parameter int SEQ_LEN         = 3,
   parameter logic [SEQ_LEN*$clog2(N_BTN)-1:0] PATTERN = 3'b110,
   parameter bit OVERLAP         = 1'b1,
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int CNT_W           = 8,
   localparam int SYM_W          = $clog2(N_BTN),
   localparam int PROG_W         = $clog2(SEQ_LEN + 1)
) (
   input  logic              cp,
   input  logic              rst,
   input  logic [N_BTN-1:0]  btn,
   output logic [PROG_W-1:0] progress,
   output logic              match,
   output logic [CNT_W-1:0]  match_count,
   output logic [15:0]       led_pin
);

   localparam logic [MAX_SEQ*MAX_SYM_W-1:0] PAT_EXT = (MAX_SEQ*MAX_SYM_W)'(PATTERN);
   localparam logic [(MAX_SEQ+1)*FAIL_W-1:0] FAILS  = fail_table(PAT_EXT, SEQ_LEN, SYM_W);
   localparam int FAIL_END = int'(FAILS[SEQ_LEN*FAIL_W +: FAIL_W]);

   if (!params_ok(N_BTN, SEQ_LEN, DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_params
      $error("btn_seq_detector: parameter out of range");
   end

   logic [N_BTN-1:0]  level, press, ev;
   logic [3:0]        n_ev;
   logic [SYM_W-1:0]  sym;
   logic              sym_valid, sym_invalid;
   logic [PROG_W-1:0] progress_nxt;
   logic              match_nxt;
   logic              seen;

   for (genvar g = 0; g < N_BTN; g++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .cp      (cp),
         .rst     (rst),
         .btn_raw (btn[g]),
         .level   (level[g]),
         .press   (press[g])
      );
   end

   // A pulse whose debounced level already fell back is ignored; this can
   // only happen with a single-cycle debounce window.
   assign ev = press & level;

   always_comb begin
      n_ev = '0;
      sym  = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (ev[i]) begin
            n_ev = n_ev + 4'd1;
            sym  = SYM_W'(i);
         end
      end
   end

   assign sym_valid   = (n_ev == 4'd1);
   assign sym_invalid = (n_ev > 4'd1);

   // Walk the failure chain until the symbol extends a prefix or we hit 0.
   // The chain is at most SEQ_LEN long, so the loop bound covers every case.
   always_comb begin
      int q;
      int ext;
      progress_nxt = progress;
      match_nxt    = 1'b0;
      q            = int'(progress);
      ext          = -1;
      if (sym_invalid) begin
         progress_nxt = '0;
      end else if (sym_valid) begin
         for (int i = 0; i <= SEQ_LEN; i++) begin
            if (ext < 0) begin
               if (PAT_EXT[q*SYM_W +: SYM_W] == sym) ext = q + 1;
               else if (q == 0)                      ext = 0;
               else                                  q = int'(FAILS[q*FAIL_W +: FAIL_W]);
            end
         end
         if (ext < 0) ext = 0;
         if (ext == SEQ_LEN) begin
            match_nxt    = 1'b1;
            progress_nxt = OVERLAP ? PROG_W'(FAIL_END) : '0;
         end else begin
            progress_nxt = PROG_W'(ext);
         end
      end
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         progress    <= '0;
         match       <= 1'b0;
         match_count <= '0;
         seen        <= 1'b0;
      end else begin
         progress <= progress_nxt;
         match    <= match_nxt;
         if (match_nxt && (match_count != '1))
            match_count <= match_count + 1'b1;
         if (match_nxt)
            seen <= 1'b1;
         else if (sym_valid || sym_invalid)
            seen <= 1'b0;
      end
   end

   always_comb begin
      led_pin                              = '0;
      led_pin[LED_SEEN]                    = seen;
      led_pin[LED_PROG_LO +: LED_PROG_W]   = LED_PROG_W'(progress);
      led_pin[LED_CNT_LO  +: LED_CNT_W]    = LED_CNT_W'(match_count);
   end

endmodule

// File: tb/tb_btn_seq_detector.sv
// tb_btn_seq_detector
// Directed bench for btn_seq_detector with a 4-cycle debounce window.
// Four instances share btn/rst: default pattern, pattern 0,1,0 with and
// without overlap, and the default pattern with a 2-bit match counter.
module tb_btn_seq_detector;

   logic       cp = 1'b0;
   logic       rst;
   logic [1:0] btn;

   logic [1:0]  p_def, p_alt, p_noov, p_sat;
   logic        m_def, m_alt, m_noov, m_sat;
   logic [7:0]  c_def, c_alt, c_noov;
   logic [1:0]  c_sat;
   logic [15:0] l_def, l_alt, l_noov, l_sat;

   int total  = 0;
   int passed = 0;
   int n_def  = 0, n_alt = 0, n_noov = 0, n_sat = 0;
   int snap_def, snap_alt, snap_noov;

   always #5 cp = ~cp;

   btn_seq_detector #(.N_BTN(2), .SEQ_LEN(3), .PATTERN(3'b110), .OVERLAP(1'b1),
                      .DEBOUNCE_CYCLES(4), .CNT_W(8)) u_def (
      .cp(cp), .rst(rst), .btn(btn), .progress(p_def), .match(m_def),
      .match_count(c_def), .led_pin(l_def));

   btn_seq_detector #(.N_BTN(2), .SEQ_LEN(3), .PATTERN(3'b010), .OVERLAP(1'b1),
                      .DEBOUNCE_CYCLES(4), .CNT_W(8)) u_alt (
      .cp(cp), .rst(rst), .btn(btn), .progress(p_alt), .match(m_alt),
      .match_count(c_alt), .led_pin(l_alt));

   btn_seq_detector #(.N_BTN(2), .SEQ_LEN(3), .PATTERN(3'b010), .OVERLAP(1'b0),
                      .DEBOUNCE_CYCLES(4), .CNT_W(8)) u_noov (
      .cp(cp), .rst(rst), .btn(btn), .progress(p_noov), .match(m_noov),
      .match_count(c_noov), .led_pin(l_noov));

   btn_seq_detector #(.N_BTN(2), .SEQ_LEN(3), .PATTERN(3'b110), .OVERLAP(1'b1),
                      .DEBOUNCE_CYCLES(4), .CNT_W(2)) u_sat (
      .cp(cp), .rst(rst), .btn(btn), .progress(p_sat), .match(m_sat),
      .match_count(c_sat), .led_pin(l_sat));

   // Count cycles with match high, sampled on the inactive edge.
   always @(negedge cp) begin
      if (m_def)  n_def  <= n_def + 1;
      if (m_alt)  n_alt  <= n_alt + 1;
      if (m_noov) n_noov <= n_noov + 1;
      if (m_sat)  n_sat  <= n_sat + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge cp);
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic press(input int i);
      btn[i] = 1'b1;
      cyc(8);
      btn[i] = 1'b0;
      cyc(8);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic take_snap();
      snap_def  = n_def;
      snap_alt  = n_alt;
      snap_noov = n_noov;
   endtask

   initial begin
      rst = 1'b1;
      btn = 2'b00;
      cyc(3);
      rst = 1'b0;
      cyc(1);

      // Reset state
      check("rst_progress", int'(p_def), 0);
      check("rst_match", int'(m_def), 0);
      check("rst_count", int'(c_def), 0);
      check("rst_led", int'(l_def), 0);

      // Default pattern 0,1,1 with latency and pulse-width checks
      take_snap();
      btn[0] = 1'b1;
      cyc(7);
      check("lat_before", int'(p_def), 0);
      cyc(1);
      check("lat_at", int'(p_def), 1);
      btn[0] = 1'b0;
      cyc(8);
      press(1);
      check("p_after_01", int'(p_def), 2);
      btn[1] = 1'b1;
      cyc(7);
      check("match_early", int'(m_def), 0);
      cyc(1);
      check("match_pulse", int'(m_def), 1);
      check("p_after_match", int'(p_def), 0);
      check("count_on_match", int'(c_def), 1);
      cyc(1);
      check("match_end", int'(m_def), 0);
      btn[1] = 1'b0;
      cyc(8);
      check("match_pulses_011", n_def - snap_def, 1);
      check("led_seen", int'(l_def[0]), 1);
      check("led_count", int'(l_def[15:8]), 1);
      check("led_prog0", int'(l_def[7:4]), 0);
      press(0);
      check("led_seen_clear", int'(l_def[0]), 0);
      check("led_prog1", int'(l_def[7:4]), 1);

      // Presses 0,0,1,1
      do_reset();
      take_snap();
      press(0);
      press(0);
      check("p_after_00", int'(p_def), 1);
      press(1);
      check("p_after_001", int'(p_def), 2);
      press(1);
      check("match_0011", n_def - snap_def, 1);
      check("count_0011", int'(c_def), 1);
      check("p_after_0011", int'(p_def), 0);

      // Pattern 0,1,0 on presses 0,1,0,1,0
      do_reset();
      take_snap();
      press(0);
      press(1);
      press(0);
      check("ov_p_3", int'(p_alt), 1);
      check("noov_p_3", int'(p_noov), 0);
      press(1);
      check("ov_p_4", int'(p_alt), 2);
      check("noov_p_4", int'(p_noov), 0);
      press(0);
      check("ov_matches", n_alt - snap_alt, 2);
      check("ov_final_p", int'(p_alt), 1);
      check("ov_count", int'(c_alt), 2);
      check("noov_matches", n_noov - snap_noov, 1);
      check("noov_final_p", int'(p_noov), 1);
      check("noov_count", int'(c_noov), 1);

      // Short glitches on btn0 never produce an event
      do_reset();
      take_snap();
      for (int w = 1; w <= 3; w++) begin
         btn[0] = 1'b1;
         cyc(w);
         btn[0] = 1'b0;
         cyc(5);
      end
      cyc(6);
      check("glitch_p", int'(p_def), 0);
      check("glitch_match", n_def - snap_def, 0);

      // Two simultaneous presses at progress 2
      do_reset();
      take_snap();
      press(0);
      press(1);
      check("simul_pre", int'(p_def), 2);
      btn = 2'b11;
      cyc(8);
      check("simul_p", int'(p_def), 0);
      btn = 2'b00;
      cyc(8);
      check("simul_match", n_def - snap_def, 0);

      // Reset mid-sequence after one completed match
      do_reset();
      press(0);
      press(1);
      press(1);
      check("pre_rst_count", int'(c_def), 1);
      press(0);
      press(1);
      check("pre_rst_p", int'(p_def), 2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("rst_mid_p", int'(p_def), 0);
      check("rst_mid_count", int'(c_def), 0);
      check("rst_mid_led", int'(l_def), 0);
      take_snap();
      press(1);
      check("post_rst_p", int'(p_def), 0);
      check("post_rst_match", n_def - snap_def, 0);

      // Saturating 2-bit counter over four matches
      do_reset();
      for (int r = 0; r < 4; r++) begin
         press(0);
         press(1);
         press(1);
      end
      check("sat_count", int'(c_sat), 3);
      check("sat_led_count", int'(l_sat[15:8]), 3);
      check("wide_count", int'(c_def), 4);
      check("sat_led_seen", int'(l_sat[0]), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
